// File: rtl/jnav_pkg.sv
// Shared types and default constants for the JNAV spreader slice.
package jnav_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StRun
    } jnav_state_e;

    localparam int unsigned JNAV_CODE_LEN       = 10230;
    localparam int unsigned JNAV_EPOCHS_PER_BIT = 20;

endpackage

// File: rtl/jnav_bit_fifo.sv
// 1-bit synchronous FIFO; push is ignored when full, pop is ignored when empty.
module jnav_bit_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [Depth-1:0] mem_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/jnav_spreader.sv
// XORs the PRN chip stream with nav bits held for EPOCHS_PER_BIT code epochs.
// Define JNAV_SPREADER_STATUS_EN to expose the per-chip counter ports.
module jnav_spreader
    import jnav_pkg::*;
#(
    parameter int unsigned CODE_LEN       = JNAV_CODE_LEN,
    parameter int unsigned EPOCHS_PER_BIT = JNAV_EPOCHS_PER_BIT,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned CW = $clog2(CODE_LEN),
    localparam int unsigned EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          chip_in_i,
    input  logic          chip_valid_i,
    input  logic          data_bit_i,
    input  logic          data_valid_i,
    output logic          data_ready_o,
    output logic          spread_out_o,
    output logic          spread_valid_o,
    output logic          epoch_strobe_o,
    output logic          bit_strobe_o,
    output logic          underrun_o,
`ifdef JNAV_SPREADER_STATUS_EN
    output logic [CW-1:0] chip_count_o,
    output logic [EW-1:0] epoch_count_o,
`endif
    output logic          busy_o
);

    localparam logic [CW-1:0] ChipMax  = CW'(CODE_LEN - 1);
    localparam logic [EW-1:0] EpochMax = EW'(EPOCHS_PER_BIT - 1);

    jnav_state_e   state_q, state_d;
    logic [CW-1:0] chip_cnt_q, chip_cnt_d;
    logic [EW-1:0] epoch_cnt_q, epoch_cnt_d;
    logic          cur_bit_q, cur_bit_d;
    logic          underrun_q, underrun_d;
    logic          spread_q, spread_d;
    logic          valid_q, valid_d;
    logic          estr_q, estr_d;
    logic          bstr_q, bstr_d;
`ifdef JNAV_SPREADER_STATUS_EN
    logic [CW-1:0] chip_count_q, chip_count_d;
    logic [EW-1:0] epoch_count_q, epoch_count_d;
`endif

    logic fifo_push, fifo_pop, fifo_rd, fifo_full, fifo_empty;
    logic last_chip, last_epoch;

    assign fifo_push  = data_valid_i && !fifo_full;
    assign last_chip  = (chip_cnt_q == ChipMax);
    assign last_epoch = (epoch_cnt_q == EpochMax);

    jnav_bit_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (data_bit_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StPrime;
            StPrime: if (!fifo_empty) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
        // stop overrides everything, including a coincident start.
        if (stop_i) state_d = StIdle;
    end

    always_comb begin
        fifo_pop    = 1'b0;
        chip_cnt_d  = chip_cnt_q;
        epoch_cnt_d = epoch_cnt_q;
        cur_bit_d   = cur_bit_q;
        underrun_d  = underrun_q;
        spread_d    = 1'b0;
        valid_d     = 1'b0;
        estr_d      = 1'b0;
        bstr_d      = 1'b0;
`ifdef JNAV_SPREADER_STATUS_EN
        chip_count_d  = '0;
        epoch_count_d = '0;
`endif
        if (stop_i) begin
            chip_cnt_d  = '0;
            epoch_cnt_d = '0;
        end else if (state_q == StPrime && !fifo_empty) begin
            fifo_pop    = 1'b1;
            cur_bit_d   = fifo_rd;
            chip_cnt_d  = '0;
            epoch_cnt_d = '0;
        end else if (state_q == StRun && chip_valid_i) begin
            spread_d = chip_in_i ^ cur_bit_q;
            valid_d  = 1'b1;
            estr_d   = last_chip;
            bstr_d   = last_chip && last_epoch;
`ifdef JNAV_SPREADER_STATUS_EN
            chip_count_d  = chip_cnt_q;
            epoch_count_d = epoch_cnt_q;
`endif
            if (!last_chip) begin
                chip_cnt_d = chip_cnt_q + CW'(1);
            end else begin
                chip_cnt_d = '0;
                if (!last_epoch) begin
                    epoch_cnt_d = epoch_cnt_q + EW'(1);
                end else begin
                    epoch_cnt_d = '0;
                    // A missing bit sends raw chips until the next boundary retries.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        cur_bit_d = fifo_rd;
                    end else begin
                        underrun_d = 1'b1;
                        cur_bit_d  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chip_cnt_q  <= '0;
            epoch_cnt_q <= '0;
            cur_bit_q   <= 1'b0;
            underrun_q  <= 1'b0;
            spread_q    <= 1'b0;
            valid_q     <= 1'b0;
            estr_q      <= 1'b0;
            bstr_q      <= 1'b0;
`ifdef JNAV_SPREADER_STATUS_EN
            chip_count_q  <= '0;
            epoch_count_q <= '0;
`endif
        end else begin
            chip_cnt_q  <= chip_cnt_d;
            epoch_cnt_q <= epoch_cnt_d;
            cur_bit_q   <= cur_bit_d;
            underrun_q  <= underrun_d;
            spread_q    <= spread_d;
            valid_q     <= valid_d;
            estr_q      <= estr_d;
            bstr_q      <= bstr_d;
`ifdef JNAV_SPREADER_STATUS_EN
            chip_count_q  <= chip_count_d;
            epoch_count_q <= epoch_count_d;
`endif
        end
    end

    assign data_ready_o   = !fifo_full;
    assign spread_out_o   = spread_q;
    assign spread_valid_o = valid_q;
    assign epoch_strobe_o = estr_q;
    assign bit_strobe_o   = bstr_q;
    assign underrun_o     = underrun_q;
    assign busy_o         = (state_q != StIdle);
`ifdef JNAV_SPREADER_STATUS_EN
    assign chip_count_o  = chip_count_q;
    assign epoch_count_o = epoch_count_q;
`endif

endmodule
